// File: rtl/seq_110110_tx_if.sv
// Bundle of burst control inputs and serial stream outputs for the pattern transmitter.
// The master side issues bursts and the slave side (the transmitter) drives the stream.
`timescale 1ns/1ps
interface seq_110110_tx_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frames_sent;

  modport master (
    output start, rep_cnt, gap, abort,
    input  x, x_valid, busy, done, frames_sent
  );

  modport slave (
    input  start, rep_cnt, gap, abort,
    output x, x_valid, busy, done, frames_sent
  );
endinterface

// File: rtl/seq_110110_tx.sv
// Serial pattern transmitter: sends PATTERN MSB first, one bit per clock, rep_cnt
// times per burst with optional idle gaps; every output comes straight from a register.
`timescale 1ns/1ps
module seq_110110_tx #(
  parameter int                   PATTERN_W = 6,
  parameter logic [PATTERN_W-1:0] PATTERN   = 6'b110110,
  parameter int                   CNT_W     = 8,
  parameter int                   GAP_W     = 4
) (
  input logic                clk,
  input logic                rst,
  seq_110110_tx_if.slave     bus
);

  localparam int                 IDX_W   = $clog2(PATTERN_W);
  localparam logic [IDX_W-1:0]   IDX_MSB = IDX_W'(PATTERN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_bit_idx;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [GAP_W-1:0] r_gap_len;
  logic [CNT_W-1:0] r_rep_left;
  logic [CNT_W-1:0] r_frames;
  logic             r_x;
  logic             r_x_valid;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nx;
  logic [IDX_W-1:0] w_bit_idx_nx;
  logic [GAP_W-1:0] w_gap_cnt_nx;
  logic [GAP_W-1:0] w_gap_len_nx;
  logic [CNT_W-1:0] w_rep_left_nx;
  logic [CNT_W-1:0] w_frames_nx;
  logic             w_x_nx;
  logic             w_x_valid_nx;
  logic             w_busy_nx;
  logic             w_done_nx;

  logic [IDX_W-1:0] w_idx_dec;
  logic [CNT_W-1:0] w_rep_dec;

  function automatic logic pat_bit(input logic [IDX_W-1:0] idx);
    return PATTERN[idx];
  endfunction

  assign w_idx_dec = r_bit_idx - IDX_W'(1);
  assign w_rep_dec = r_rep_left - CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_idx  <= '0;
      r_gap_cnt  <= '0;
      r_gap_len  <= '0;
      r_rep_left <= '0;
      r_frames   <= '0;
      r_x        <= 1'b0;
      r_x_valid  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_bit_idx  <= w_bit_idx_nx;
      r_gap_cnt  <= w_gap_cnt_nx;
      r_gap_len  <= w_gap_len_nx;
      r_rep_left <= w_rep_left_nx;
      r_frames   <= w_frames_nx;
      r_x        <= w_x_nx;
      r_x_valid  <= w_x_valid_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
    end
  end

  // Next-state logic also computes next output values, so outputs stay registered.
  always_comb begin
    w_state_nx    = r_state;
    w_bit_idx_nx  = r_bit_idx;
    w_gap_cnt_nx  = r_gap_cnt;
    w_gap_len_nx  = r_gap_len;
    w_rep_left_nx = r_rep_left;
    w_frames_nx   = r_frames;
    w_x_nx        = 1'b0;
    w_x_valid_nx  = 1'b0;
    w_busy_nx     = 1'b0;
    w_done_nx     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.rep_cnt != '0)) begin
          w_state_nx    = S_SHIFT;
          w_bit_idx_nx  = IDX_MSB;
          w_rep_left_nx = bus.rep_cnt;
          w_gap_len_nx  = bus.gap;
          w_gap_cnt_nx  = '0;
          w_frames_nx   = '0;
          w_x_nx        = pat_bit(IDX_MSB);
          w_x_valid_nx  = 1'b1;
          w_busy_nx     = 1'b1;
        end
      end

      S_SHIFT: begin
        if (bus.abort) begin
          w_state_nx   = S_IDLE;
          w_bit_idx_nx = '0;
        end else if (r_bit_idx != '0) begin
          w_bit_idx_nx = w_idx_dec;
          w_x_nx       = pat_bit(w_idx_dec);
          w_x_valid_nx = 1'b1;
          w_busy_nx    = 1'b1;
        end else begin
          // Leaving the LSB: this pattern is complete.
          w_frames_nx   = r_frames + CNT_W'(1);
          w_rep_left_nx = w_rep_dec;
          if (w_rep_dec == '0) begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
          end else if (r_gap_len != '0) begin
            w_state_nx   = S_GAP;
            w_gap_cnt_nx = r_gap_len;
            w_busy_nx    = 1'b1;
          end else begin
            w_bit_idx_nx = IDX_MSB;
            w_x_nx       = pat_bit(IDX_MSB);
            w_x_valid_nx = 1'b1;
            w_busy_nx    = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (bus.abort) begin
          w_state_nx   = S_IDLE;
          w_gap_cnt_nx = '0;
        end else if (r_gap_cnt <= GAP_W'(1)) begin
          w_state_nx   = S_SHIFT;
          w_gap_cnt_nx = '0;
          w_bit_idx_nx = IDX_MSB;
          w_x_nx       = pat_bit(IDX_MSB);
          w_x_valid_nx = 1'b1;
          w_busy_nx    = 1'b1;
        end else begin
          w_gap_cnt_nx = r_gap_cnt - GAP_W'(1);
          w_busy_nx    = 1'b1;
        end
      end

      S_DONE: begin
        w_state_nx = S_IDLE;
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign bus.x           = r_x;
  assign bus.x_valid     = r_x_valid;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.frames_sent = r_frames;

endmodule
